// File: rtl/uart_status_monitor.sv
// 8N1 UART receiver for the harness txd line that watches the byte stream for the
// tokens "PASS" and "FAIL" and raises sticky success/failure indications.
module uart_status_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int COUNT_W      = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_rxd,
  output logic               io_byte_valid,
  output logic [7:0]         io_byte,
  output logic [COUNT_W-1:0] io_byte_count,
  output logic               io_frame_err,
  output logic               io_success,
  output logic               io_failure
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   TOKEN_PASS = 32'h50415353;
  localparam logic [31:0]   TOKEN_FAIL = 32'h4641494C;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [31:0]   window;
  logic          match_pass;
  logic          match_fail;

  // The window already holds the newest byte while io_byte_valid is high.
  assign match_pass = (window == TOKEN_PASS);
  assign match_fail = (window == TOKEN_FAIL);

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      window        <= '0;
      io_byte_valid <= 1'b0;
      io_byte       <= '0;
      io_byte_count <= '0;
      io_frame_err  <= 1'b0;
      io_success    <= 1'b0;
      io_failure    <= 1'b0;
    end else begin
      rx_m          <= io_rxd;
      rx_s          <= rx_m;
      io_byte_valid <= 1'b0;

      // First token wins; both flags freeze once either is set.
      if (io_byte_valid && !io_success && !io_failure) begin
        if (match_pass)      io_success <= 1'b1;
        else if (match_fail) io_failure <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_HALF) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (rx_s) begin
              state         <= IDLE;
              io_byte_valid <= 1'b1;
              io_byte       <= shift;
              window        <= {window[23:0], shift};
              if (io_byte_count != '1) io_byte_count <= io_byte_count + COUNT_W'(1);
            end else begin
              io_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_monitor.sv
// Bench for uart_status_monitor: drives 8N1 frames on io_rxd and compares the
// received bytes, counters and sticky flags against a byte-history model.
`timescale 1ns/1ps
module tb_uart_status_monitor;

  localparam int C = 16;
  localparam int COUNT_W = 32;
  localparam int LAT = 2 + C / 2 + 9 * C + 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               io_rxd = 1'b1;
  logic               io_byte_valid;
  logic [7:0]         io_byte;
  logic [COUNT_W-1:0] io_byte_count;
  logic               io_frame_err;
  logic               io_success;
  logic               io_failure;

  uart_status_monitor #(.CLKS_PER_BIT(C), .COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset(reset), .io_rxd(io_rxd),
    .io_byte_valid(io_byte_valid), .io_byte(io_byte), .io_byte_count(io_byte_count),
    .io_frame_err(io_frame_err), .io_success(io_success), .io_failure(io_failure)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_start = 0;
  int succ_cyc = -1;
  int fail_cyc = -1;
  logic [7:0] got_q[$];
  int         vld_cyc_q[$];
  logic [7:0] hist[$];
  int         err_frames = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (io_byte_valid === 1'b1) begin
      got_q.push_back(io_byte);
      vld_cyc_q.push_back(cyc);
    end
    if (io_success === 1'b1 && succ_cyc < 0) succ_cyc = cyc;
    if (io_failure === 1'b1 && fail_cyc < 0) fail_cyc = cyc;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: first 4-byte run of good bytes equal to a token decides the outcome.
  function automatic void model_flags(output bit s, output bit f);
    logic [31:0] w;
    s = 1'b0;
    f = 1'b0;
    for (int i = 3; i < hist.size(); i++) begin
      w = {hist[i-3], hist[i-2], hist[i-1], hist[i]};
      if (w == "PASS") begin s = 1'b1; return; end
      if (w == "FAIL") begin f = 1'b1; return; end
    end
  endfunction

  task automatic do_reset();
    @(negedge clock);
    io_rxd = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    got_q.delete();
    vld_cyc_q.delete();
    hist.delete();
    succ_cyc = -1;
    fail_cyc = -1;
    err_frames = 0;
  endtask

  // Called on a negedge; leaves the line high for gap cycles afterwards.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    io_rxd = 1'b0;
    last_start = cyc;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      io_rxd = b[i];
      repeat (C) @(negedge clock);
    end
    io_rxd = stop_ok;
    repeat (C) @(negedge clock);
    io_rxd = 1'b1;
    if (stop_ok) hist.push_back(b);
    else err_frames++;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, 3);
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if (io_byte_valid !== 1'b0) $display("FAIL %s valid: got %b want 0", tag, io_byte_valid); else n_pass++;
    n_checks++;
    if (io_byte !== 8'h00) $display("FAIL %s byte: got %h want 00", tag, io_byte); else n_pass++;
    n_checks++;
    if (io_byte_count !== '0) $display("FAIL %s count: got %0d want 0", tag, io_byte_count); else n_pass++;
    n_checks++;
    if (io_frame_err !== 1'b0) $display("FAIL %s frame_err: got %b want 0", tag, io_frame_err); else n_pass++;
    n_checks++;
    if (io_success !== 1'b0) $display("FAIL %s success: got %b want 0", tag, io_success); else n_pass++;
    n_checks++;
    if (io_failure !== 1'b0) $display("FAIL %s failure: got %b want 0", tag, io_failure); else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (1000) @(negedge clock);
    check_idle_outputs("reset");
    n_checks++;
    if (got_q.size() != 0) $display("FAIL reset pulses: got %0d want 0", got_q.size()); else n_pass++;
  endtask

  task automatic test_single_byte();
    int lat;
    do_reset();
    send_frame(8'hA5, 1'b1, 4);
    n_checks++;
    if (got_q.size() != 1) $display("FAIL single pulses: got %0d want 1", got_q.size()); else n_pass++;
    n_checks++;
    if (io_byte !== 8'hA5) $display("FAIL single byte: got %h want a5", io_byte); else n_pass++;
    n_checks++;
    if (io_byte_count !== 32'd1) $display("FAIL single count: got %0d want 1", io_byte_count); else n_pass++;
    lat = (vld_cyc_q.size() > 0) ? vld_cyc_q[0] - last_start : -1;
    n_checks++;
    if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL single latency: got %0d want %0d+/-1", lat, LAT);
    else n_pass++;
  endtask

  task automatic test_pass_token();
    int want;
    do_reset();
    send_str("xPASS");
    send_frame(8'h0A, 1'b1, 4);
    n_checks++;
    if (io_success !== 1'b1) $display("FAIL pass success: got %b want 1", io_success); else n_pass++;
    n_checks++;
    if (io_failure !== 1'b0) $display("FAIL pass failure: got %b want 0", io_failure); else n_pass++;
    n_checks++;
    if (io_byte_count !== 32'd6) $display("FAIL pass count: got %0d want 6", io_byte_count); else n_pass++;
    want = (vld_cyc_q.size() >= 5) ? vld_cyc_q[4] + 1 : -2;
    n_checks++;
    if (succ_cyc != want) $display("FAIL pass flag timing: got cycle %0d want %0d", succ_cyc, want); else n_pass++;
  endtask

  task automatic test_fail_first();
    do_reset();
    send_str("FAILPASS");
    n_checks++;
    if (io_failure !== 1'b1) $display("FAIL failfirst failure: got %b want 1", io_failure); else n_pass++;
    n_checks++;
    if (io_success !== 1'b0) $display("FAIL failfirst success: got %b want 0", io_success); else n_pass++;
    n_checks++;
    if (io_byte_count !== 32'd8) $display("FAIL failfirst count: got %0d want 8", io_byte_count); else n_pass++;
  endtask

  task automatic test_frame_error();
    logic [7:0] junk;
    junk = 8'($urandom_range(0, 255));
    do_reset();
    send_frame(junk, 1'b0, 2 * C);
    send_frame(8'h3C, 1'b1, 4);
    n_checks++;
    if (io_frame_err !== 1'b1) $display("FAIL ferr flag: got %b want 1", io_frame_err); else n_pass++;
    n_checks++;
    if (io_byte !== 8'h3C) $display("FAIL ferr byte: got %h want 3c", io_byte); else n_pass++;
    n_checks++;
    if (io_byte_count !== 32'd1) $display("FAIL ferr count: got %0d want 1", io_byte_count); else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    io_rxd = 1'b0;
    repeat (4) @(negedge clock);
    io_rxd = 1'b1;
    repeat (12 * C) @(negedge clock);
    n_checks++;
    if (got_q.size() != 0) $display("FAIL glitch pulses: got %0d want 0", got_q.size()); else n_pass++;
    n_checks++;
    if (io_frame_err !== 1'b0) $display("FAIL glitch frame_err: got %b want 0", io_frame_err); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] s_chr;
    s_chr = "S";
    do_reset();
    send_str("PA");
    io_rxd = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      io_rxd = s_chr[i];
      repeat (C) @(negedge clock);
    end
    do_reset();
    check_idle_outputs("midreset");
    send_str("PASS");
    n_checks++;
    if (io_success !== 1'b1) $display("FAIL midreset success: got %b want 1", io_success); else n_pass++;
    n_checks++;
    if (io_byte_count !== 32'd4) $display("FAIL midreset count: got %0d want 4", io_byte_count); else n_pass++;
  endtask

  task automatic test_back_to_back_random();
    bit s, f;
    bit ok;
    int gap;
    logic [7:0] b;
    string alpha;
    alpha = "PASFIL";
    do_reset();
    for (int k = 0; k < 40; k++) begin
      b = ($urandom_range(0, 3) != 0) ? alpha[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      gap = ok ? $urandom_range(0, 2) : C + $urandom_range(0, 4);
      send_frame(b, ok, gap);
    end
    repeat (4) @(negedge clock);
    model_flags(s, f);
    n_checks++;
    if (got_q.size() != hist.size()) $display("FAIL rand pulses: got %0d want %0d", got_q.size(), hist.size());
    else n_pass++;
    for (int i = 0; i < hist.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== hist[i]) $display("FAIL rand byte%0d: got %h want %h", i, got_q[i], hist[i]);
      else n_pass++;
    end
    n_checks++;
    if (io_byte_count !== COUNT_W'(hist.size()))
      $display("FAIL rand count: got %0d want %0d", io_byte_count, hist.size());
    else n_pass++;
    n_checks++;
    if (io_frame_err !== (err_frames > 0)) $display("FAIL rand frame_err: got %b want %b", io_frame_err, err_frames > 0);
    else n_pass++;
    n_checks++;
    if (io_success !== s) $display("FAIL rand success: got %b want %b", io_success, s); else n_pass++;
    n_checks++;
    if (io_failure !== f) $display("FAIL rand failure: got %b want %b", io_failure, f); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_pass_token();
    test_fail_first();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back_random();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
